// File: rtl/alu_issue_stage_if.sv
// Handshake/bus bundle between the issue stage, its instruction source and the ALU side.
// slave = the issue stage view; master = the surrounding logic (or bench) view.
interface alu_issue_stage_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [OPW-1:0]  alu_op;
  logic [4:0]      rd_addr;
  logic            rd_we;
  logic            illegal;

  modport slave (
    input  instr_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output instr_ready, out_valid, alu_in1, alu_in2, alu_op, rd_addr, rd_we, illegal
  );

  modport master (
    output instr_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  instr_ready, out_valid, alu_in1, alu_in2, alu_op, rd_addr, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage feeding the ALU through a 2-entry skid buffer.
// Optional macro ALU_ISSUE_X0_FORCE_EN: zero x0 operands and suppress rd_we for rd=x0.
//
// state   | meaning
// S_EMPTY | no entry held, out_valid=0, instr_ready=1
// S_ONE   | main entry valid, instr_ready=1
// S_TWO   | main and skid entries valid, instr_ready=0
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [OPW-1:0]  op;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  entry_t r_main;
  entry_t r_skid;
  entry_t w_dec;
  entry_t w_out;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_legal;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;

  logic w_out_valid;
  logic w_in_ready;
  logic w_accept;
  logic w_issue;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  assign w_opc   = bus.instr[6:0];
  assign w_f3    = bus.instr[14:12];
  assign w_f7    = bus.instr[31:25];
  assign w_imm_i = XLEN'($signed(bus.instr[31:20]));
  assign w_imm_u = XLEN'($signed({bus.instr[31:12], 12'b0}));

  // Input-side decode; the result is what gets captured on accept.
  always_comb begin
    w_dec    = '0;
    w_legal  = 1'b0;
    w_dec.rd = bus.instr[11:7];
    case (w_opc)
      OPC_OP: begin
        w_legal   = (w_f7 == F7_ZERO) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_dec.op  = OPW'({bus.instr[30], w_f3, 1'b1});
        w_dec.in1 = bus.rs1_data;
        w_dec.in2 = bus.rs2_data;
`ifdef ALU_ISSUE_X0_FORCE_EN
        if (bus.instr[19:15] == 5'd0) w_dec.in1 = '0;
        if (bus.instr[24:20] == 5'd0) w_dec.in2 = '0;
`endif
      end
      OPC_OP_IMM: begin
        case (w_f3)
          3'b001:  w_legal = (w_f7 == F7_ZERO);
          3'b101:  w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
        w_dec.op  = OPW'({bus.instr[30], w_f3, 1'b0});
        w_dec.in1 = bus.rs1_data;
        w_dec.in2 = w_imm_i;
`ifdef ALU_ISSUE_X0_FORCE_EN
        if (bus.instr[19:15] == 5'd0) w_dec.in1 = '0;
`endif
      end
      OPC_LUI: begin
        w_legal   = 1'b1;
        w_dec.in2 = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal   = 1'b1;
        w_dec.in1 = bus.pc;
        w_dec.in2 = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase

`ifdef ALU_ISSUE_X0_FORCE_EN
    w_dec.we = w_legal && (w_dec.rd != 5'd0);
`else
    w_dec.we = w_legal;
`endif
    w_dec.ill = ~w_legal;

    // Illegal entries still flow through, but carry no operands or work.
    if (!w_legal) begin
      w_dec.in1 = '0;
      w_dec.in2 = '0;
      w_dec.op  = '0;
      w_dec.we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_accept && !w_issue)      w_state_nxt = S_TWO;
        else if (!w_accept && w_issue) w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_issue) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Ready/valid depend only on the state register, never on same-cycle inputs.
  always_comb begin
    w_out_valid    = (r_state != S_EMPTY);
    w_in_ready     = (r_state != S_TWO);
    w_accept       = bus.instr_valid && w_in_ready;
    w_issue        = w_out_valid && bus.out_ready;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      S_EMPTY: w_ld_main_in = w_accept;
      S_ONE: begin
        w_ld_main_in = w_accept && w_issue;
        w_ld_skid    = w_accept && !w_issue;
      end
      S_TWO:   w_ld_main_skid = w_issue;
      default: ;
    endcase
    w_out = w_out_valid ? r_main : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)        r_main <= w_dec;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= w_dec;
    end
  end

  assign bus.out_valid   = w_out_valid;
  assign bus.instr_ready = w_in_ready;
  assign bus.alu_in1     = w_out.in1;
  assign bus.alu_in2     = w_out.in2;
  assign bus.alu_op      = w_out.op;
  assign bus.rd_addr     = w_out.rd;
  assign bus.rd_we       = w_out.we;
  assign bus.illegal     = w_out.ill;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-and-issue stage directly upstream of the RV32I 32-bit ALU.
- Accepts a fetched instruction plus register-file read data, builds the ALU operands in1/in2 and the 5-bit op code, and registers them.
- Uses a 2-entry skid buffer with valid/ready on both sides, so instr_ready is a pure register output.
- Supports OP, OP-IMM, LUI and AUIPC. Any other encoding is issued with an illegal flag.

Parameters:
- XLEN, 32, datapath width; equals `width.
- OPW, 5, ALU op width; equals `OPWIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous; discards all buffered entries.
- instr_valid  in  1  upstream entry valid.
- instr_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- pc  in  32  instruction address, for AUIPC.
- rs1_data  in  32  register-file read of instr[19:15]; valid with instr_valid.
- rs2_data  in  32  register-file read of instr[24:20]; valid with instr_valid.
- out_valid  out  1  issued entry valid.
- out_ready  in  1  ALU/writeback side can take the entry.
- alu_in1  out  32  ALU operand 1.
- alu_in2  out  32  ALU operand 2.
- alu_op  out  5  ALU op code.
- rd_addr  out  5  destination register, instr[11:7].
- rd_we  out  1  writeback enable.
- illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset, and also flush: both entries invalid next cycle. Outputs become out_valid=0, instr_ready=1, alu_in1=0, alu_in2=0, alu_op=0, rd_addr=0, rd_we=0, illegal=0.
- Reset takes priority over flush; flush takes priority over any same-cycle accept or issue.
- Accept handshake: instr_valid & instr_ready. Issue handshake: out_valid & out_ready.
- Decode is combinational on the input side. Results are captured on accept.
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Op encoding, with funct3=instr[14:12]:
  - R-type (0110011): alu_op = {instr[30], funct3, 1}.
  - OP-IMM (0010011): alu_op = {instr[30], funct3, 0}.
  - LUI and AUIPC: alu_op = 00000.
- Operands:
  - R-type: in1=rs1_data, in2=rs2_data.
  - OP-IMM: in1=rs1_data, in2=sign-extend(instr[31:20]).
  - LUI: in1=0, in2={instr[31:12], 12'b0}.
  - AUIPC: in1=pc, in2={instr[31:12], 12'b0}.
- Legality:
  - R-type: funct7 must be 0000000, or 0100000 only when funct3 is 000 or 101.
  - OP-IMM, funct3=001: instr[31:25] must be 0000000.
  - OP-IMM, funct3=101: instr[31:25] must be 0000000 or 0100000.
  - Any other opcode is illegal.
  - An illegal entry is still issued, with illegal=1, rd_we=0, alu_op=00000, alu_in1=0, alu_in2=0.
- rd_we=1 for every legal entry.
- Buffer states:
  - EMPTY: out_valid=0, instr_ready=1.
  - ONE: main entry valid, instr_ready=1.
  - TWO: main and skid entries valid, instr_ready=0.
- Transitions:
  - EMPTY, accept -> ONE.
  - ONE, accept without issue -> TWO.
  - ONE, issue without accept -> EMPTY.
  - ONE, accept and issue in the same cycle -> ONE; the new entry loads into main.
  - TWO, issue -> ONE; skid moves to main.
  - TWO never accepts.
- Outputs always come from the main entry. Order is strictly FIFO.
- Outputs hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: ALU_ISSUE_X0_FORCE_EN.
- Defined:
  - An rs1 field of 0 forces in1=0 for R-type and OP-IMM.
  - An rs2 field of 0 forces in2=0 for R-type.
  - rd_addr=0 forces rd_we=0.
- Undefined: rs1_data and rs2_data pass through unchanged. rd_we follows legality only, and the register file ignores x0 writes.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 -> one cycle later: out_valid=1, in1=5, in2=7, alu_op=00001, rd_addr=3, rd_we=1.
- srai x4,x1,3 (0x4030D213), rs1_data=0x80000000 -> alu_op=11010, in2=0x00000403; then slli with instr[31:25]=0100000 -> illegal=1, rd_we=0.
- lui x5,0x12345 (0x123452B7) -> in1=0, in2=0x12345000, alu_op=00000. auipc x6,1 at pc=0x100 -> in1=0x100, in2=0x1000.
- Hold out_ready=0 and present 3 back-to-back valid instructions:
  - 2 accepted; instr_ready=0 after the second.
  - Outputs stay stable.
  - Release out_ready -> entries issue in order, 1 per cycle; the third is accepted the cycle after the first issue.
- TWO state, assert flush together with instr_valid=1 -> next cycle out_valid=0, instr_ready=1, nothing accepted.
- ALU_ISSUE_X0_FORCE_EN defined, addi x0,x0,1 with rs1_data=0xFFFFFFFF -> in1=0, in2=1, rd_we=0. Macro undefined -> in1=0xFFFFFFFF, rd_we=1.
